// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: board geometry defaults, cell/winner codes,
// controller state encoding and a small turn helper.
// Imported by the drop controller, its board register file and the win checkers.
package connect4_pkg;

  localparam int ROWS_DEF = 6;
  localparam int COLS_DEF = 7;

  // Cell codes
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1    = 2'b01;
  localparam logic [1:0] P2    = 2'b10;

  // Outcome codes
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_PLACE,
    ST_REPORT,
    ST_OVER
  } state_t;

  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == P1) ? P2 : P1;
  endfunction

endpackage

// File: rtl/connect4_drop_ctrl_if.sv
// Drop-request and move-report channel between the drop controller, the
// player-side requester and the win checkers.
// Ports: drop_valid/drop_col/drop_ready/illegal (request side),
// move_valid/move_row/move_col/move_player (report side), p1_win/p2_win (checker results).
interface connect4_drop_ctrl_if #(
  parameter int ROWS = 6,
  parameter int COLS = 7
) ();
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic          drop_valid;
  logic [CW-1:0] drop_col;
  logic          drop_ready;
  logic          illegal;
  logic          move_valid;
  logic [RW-1:0] move_row;
  logic [CW-1:0] move_col;
  logic [1:0]    move_player;
  logic          p1_win;
  logic          p2_win;

  // master: player/checker environment; slave: the drop controller
  modport master (
    output drop_valid, drop_col, p1_win, p2_win,
    input  drop_ready, illegal, move_valid, move_row, move_col, move_player
  );

  modport slave (
    input  drop_valid, drop_col, p1_win, p2_win,
    output drop_ready, illegal, move_valid, move_row, move_col, move_player
  );
endinterface

// File: rtl/connect4_board_regs.sv
// Board register file: ROWS*COLS 2-bit cells, one combinational read port,
// one write port (applied at the clock edge), synchronous clear, async reset.
// Ports: clk, rst, clear, rd_row/rd_col -> rd_data, wr_en/wr_row/wr_col/wr_data, board (flat).
module connect4_board_regs
  import connect4_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic [$clog2(ROWS)-1:0]    rd_row,
  input  logic [$clog2(COLS)-1:0]    rd_col,
  output logic [1:0]                 rd_data,
  input  logic                       wr_en,
  input  logic [$clog2(ROWS)-1:0]    wr_row,
  input  logic [$clog2(COLS)-1:0]    wr_col,
  input  logic [1:0]                 wr_data,
  output logic [2*ROWS*COLS-1:0]     board
);
  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);

  logic [1:0]    cells [N];
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;

  // Cell (r,c) lives at linear index r*COLS + c
  assign rd_idx = IW'(rd_row) * IW'(COLS) + IW'(rd_col);
  assign wr_idx = IW'(wr_row) * IW'(COLS) + IW'(wr_col);

  // Indices past the last cell read as empty
  always_comb begin
    rd_data = EMPTY;
    for (int i = 0; i < N; i++) begin
      if (rd_idx == IW'(i)) rd_data = cells[i];
    end
  end

  // Clear beats write so a new game started mid-move leaves nothing behind
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cells[i] <= EMPTY;
    end else if (clear) begin
      for (int i = 0; i < N; i++) cells[i] <= EMPTY;
    end else if (wr_en) begin
      for (int i = 0; i < N; i++) begin
        if (wr_idx == IW'(i)) cells[i] <= wr_data;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign board[2*g +: 2] = cells[g];
  end

endmodule

// File: rtl/connect4_drop_ctrl.sv
// Connect-4 move-entry controller: accepts a column drop, scans upward for the
// lowest empty cell, writes the mover's code, reports the move to the win
// checkers, then alternates turns or latches the outcome.
// Latency: move_valid k+3 cycles after acceptance onto a column holding k pieces;
// full column -> illegal after ROWS+1; out-of-range column -> illegal after 1.
// Backpressure: drop_ready only in IDLE; requests in SCAN..REPORT and OVER are ignored.
// Ports: clk, rst, new_game, bus (slave: drop/move/win channel), board, turn, winner.
module connect4_drop_ctrl
  import connect4_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    new_game,
  connect4_drop_ctrl_if.slave     bus,
  output logic [2*ROWS*COLS-1:0]  board,
  output logic [1:0]              turn,
  output logic [1:0]              winner
);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int NCELL = ROWS * COLS;
  localparam int NW    = $clog2(NCELL + 1);

  state_t        state;
  state_t        state_nxt;

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_ptr;
  logic [NW-1:0] count;
  logic [1:0]    turn_q;
  logic [1:0]    winner_q;
  logic          illegal_q;
  logic [RW-1:0] move_row_q;
  logic [CW-1:0] move_col_q;
  logic [1:0]    move_player_q;

  logic          accept;
  logic          ptr_inc;
  logic          illegal_nxt;
  logic          wr_en;
  logic          toggle_turn;
  logic [1:0]    winner_nxt;
  logic          col_bad;
  logic [1:0]    cell_rd;

  assign col_bad = ({1'b0, bus.drop_col} >= (CW+1)'(COLS));

  connect4_board_regs #(.ROWS(ROWS), .COLS(COLS)) u_board (
    .clk     (clk),
    .rst     (rst),
    .clear   (new_game),
    .rd_row  (row_ptr),
    .rd_col  (col_q),
    .rd_data (cell_rd),
    .wr_en   (wr_en),
    .wr_row  (row_ptr),
    .wr_col  (col_q),
    .wr_data (turn_q),
    .board   (board)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    ptr_inc     = 1'b0;
    illegal_nxt = 1'b0;
    wr_en       = 1'b0;
    toggle_turn = 1'b0;
    winner_nxt  = winner_q;

    case (state)
      ST_IDLE: begin
        if (bus.drop_valid) begin
          if (col_bad) begin
            illegal_nxt = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        if (cell_rd == EMPTY) begin
          state_nxt = ST_PLACE;
        end else if (row_ptr == RW'(ROWS - 1)) begin
          illegal_nxt = 1'b1;
          state_nxt   = ST_IDLE;
        end else begin
          ptr_inc = 1'b1;
        end
      end
      ST_PLACE: begin
        wr_en     = 1'b1;
        state_nxt = ST_REPORT;
      end
      ST_REPORT: begin
        // count already includes this move (bumped in PLACE)
        if (bus.p1_win)                  winner_nxt = WIN_P1;
        else if (bus.p2_win)             winner_nxt = WIN_P2;
        else if (count == NW'(NCELL))    winner_nxt = WIN_DRAW;

        if (winner_nxt != WIN_NONE) begin
          state_nxt = ST_OVER;
        end else begin
          toggle_turn = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      ST_OVER: begin
        state_nxt = ST_OVER;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (new_game) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q         <= '0;
      row_ptr       <= '0;
      count         <= '0;
      turn_q        <= P1;
      winner_q      <= WIN_NONE;
      illegal_q     <= 1'b0;
      move_row_q    <= '0;
      move_col_q    <= '0;
      move_player_q <= EMPTY;
    end else if (new_game) begin
      // move_* deliberately keep their last values
      row_ptr   <= '0;
      count     <= '0;
      turn_q    <= P1;
      winner_q  <= WIN_NONE;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_nxt;
      winner_q  <= winner_nxt;
      if (accept) begin
        col_q   <= bus.drop_col;
        row_ptr <= '0;
      end
      if (ptr_inc) row_ptr <= row_ptr + 1'b1;
      if (wr_en) begin
        count         <= count + 1'b1;
        move_row_q    <= row_ptr;
        move_col_q    <= col_q;
        move_player_q <= turn_q;
      end
      if (toggle_turn) turn_q <= other_player(turn_q);
    end
  end

  assign bus.drop_ready  = (state == ST_IDLE);
  assign bus.illegal     = illegal_q;
  // A new game landing on the report cycle discards the move unreported
  assign bus.move_valid  = (state == ST_REPORT) && !new_game;
  assign bus.move_row    = move_row_q;
  assign bus.move_col    = move_col_q;
  assign bus.move_player = move_player_q;
  assign turn            = turn_q;
  assign winner          = winner_q;

endmodule

// File: doc/connect4_drop_ctrl.md
# connect4_drop_ctrl

Move-entry controller for the Connect-4 datapath. Accepts a column drop from the active player, finds the lowest empty cell in that column, writes the player's code into the board register file, and presents the placed cell's coordinates to the downstream win checkers (horizontal/vertical/diagonal). Samples the checkers' results, alternates turns, and latches the game outcome.

## Interface
- ROWS, 6: board rows; row 0 is the bottom row.
- COLS, 7: board columns; column 0 is leftmost.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- new_game  in  1  synchronous clear of board/turn/outcome; highest priority.
- drop_valid  in  1  drop request.
- drop_col  in  $clog2(COLS)  requested column.
- drop_ready  out  1  controller idle and accepting a request.
- illegal  out  1  one-cycle pulse: column full or out of range.
- move_valid  out  1  one-cycle pulse: a piece was placed; checker inputs are valid.
- move_row  out  $clog2(ROWS)  row of placed piece.
- move_col  out  $clog2(COLS)  column of placed piece.
- move_player  out  2  code written: 2'b01 player 1, 2'b10 player 2.
- board  out  2*ROWS*COLS  flat board; cell (r,c) at bits [2*(r*COLS+c) +: 2]; 00 empty.
- p1_win, p2_win  in  2  win flags from the checkers, combinational on board/move_*.
- turn  out  2  player to move next (2'b01/2'b10).
- winner  out  2  00 in play, 01 P1, 10 P2, 11 draw.

## Operation
- States: IDLE, SCAN, PLACE, REPORT, OVER.
- IDLE: drop_ready=1. Handshake when drop_valid && drop_ready. drop_col >= COLS: illegal pulses next cycle, stay IDLE. Otherwise latch column, row_ptr=0, go SCAN.
- SCAN: examine cell(row_ptr, col). Empty -> PLACE. Occupied and row_ptr==ROWS-1 -> illegal pulse next cycle, IDLE, turn unchanged. Otherwise row_ptr+1, stay SCAN.
- PLACE: write turn code into cell(row_ptr, col) at the end of the cycle; increment move count (width $clog2(ROWS*COLS+1)).
- REPORT: move_valid=1, move_row/col/player hold the placed cell; board reflects the write. At the end of the cycle: p1_win -> winner=01; else p2_win -> winner=10; else move count == ROWS*COLS -> winner=11. Any winner -> OVER; otherwise toggle turn, go IDLE.
- OVER: drop_ready=0; requests ignored, no illegal pulse. Only new_game or rst leaves it.
- new_game in any state: board all zero, turn=01, winner=00, count=0, state IDLE on the next edge; an in-flight move is discarded with no move_valid.
- Both win flags in the same REPORT cycle: P1 takes priority. Checkers only see a well-formed game, so this is a checker fault.
- move_* hold their last values outside REPORT.

## Timing
- Reset values: state IDLE, drop_ready=1, illegal=0, move_valid=0, move_row=0, move_col=0, move_player=00, board=0, turn=01, winner=00.
- Column holding k pieces (k<ROWS), accepted on edge E: SCAN occupies k+1 cycles, PLACE 1, REPORT 1. move_valid is high in cycle E+k+3. drop_ready is back high in cycle E+k+4 unless the game ends.
- Full column: illegal is high in cycle E+ROWS+1; drop_ready is high in the same cycle.
- Out-of-range column: illegal is high in cycle E+1 and drop_ready stays high.
- drop_ready is low from SCAN through REPORT; drop_valid is ignored there.
- rst asserted mid-move clears immediately, including during PLACE (no partial write survives).

## Structure
- connect4_pkg: ROWS/COLS defaults, cell codes EMPTY=2'b00, P1=2'b01, P2=2'b10, winner codes, and the state enum. Shared with the checker modules.
- Sub-module connect4_board_regs: ROWS*COLS 2-bit register array with one read port, one write port, synchronous clear, async reset, and a flat board output.

## Test plan
- Reset, then drop col 3 -> move_valid 3 cycles after acceptance with row 0, col 3, player 01; board cell(0,3)=01; turn becomes 10.
- Alternate six drops into col 0, then a seventh -> rows 0..5 filled alternately 01/10; seventh gives illegal ROWS+1 cycles after acceptance, board unchanged, turn unchanged.
- drop_col=7 with COLS=7 -> illegal next cycle, drop_ready stays 1, board unchanged.
- Force p1_win during the REPORT of P1's drop into col 2 -> winner=01, drop_ready=0; further drops ignored; new_game -> board 0, turn 01, winner 00.
- Fill all 42 cells with win flags held low -> winner=11 after the 42nd REPORT.
- Assert rst during SCAN of a col-4 drop onto 3 pieces -> all outputs return to reset values at once; no move_valid.
